// File: rtl/conv3x3_pkg.sv
// Shared types, kernel weights and width helpers for the 3x3 gradient convolution.
package conv3x3_pkg;

    typedef enum logic [1:0] {
        KM_SOBEL   = 2'b00,
        KM_PREWITT = 2'b01,
        KM_SCHARR  = 2'b10
    } kernel_mode_e;

    localparam int unsigned SOBEL_OUTER   = 1;
    localparam int unsigned SOBEL_INNER   = 2;
    localparam int unsigned PREWITT_OUTER = 1;
    localparam int unsigned PREWITT_INNER = 1;
    localparam int unsigned SCHARR_OUTER  = 3;
    localparam int unsigned SCHARR_INNER  = 10;

    function automatic int unsigned grad_width(input int unsigned width);
        return width + 5;
    endfunction

    // Selector 11 is treated as Sobel.
    function automatic kernel_mode_e decode_mode(input logic [1:0] sel);
        kernel_mode_e m;
        case (sel)
            2'b01:   m = KM_PREWITT;
            2'b10:   m = KM_SCHARR;
            default: m = KM_SOBEL;
        endcase
        return m;
    endfunction

    function automatic int unsigned outer_weight(input kernel_mode_e m);
        int unsigned w;
        case (m)
            KM_PREWITT: w = PREWITT_OUTER;
            KM_SCHARR:  w = SCHARR_OUTER;
            default:    w = SOBEL_OUTER;
        endcase
        return w;
    endfunction

    function automatic int unsigned inner_weight(input kernel_mode_e m);
        int unsigned w;
        case (m)
            KM_PREWITT: w = PREWITT_INNER;
            KM_SCHARR:  w = SCHARR_INNER;
            default:    w = SOBEL_INNER;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/conv3x3_linebuf.sv
// Two row buffers holding rows r-1 and r-2; read and written at the current column.
module conv3x3_linebuf #(
    parameter int unsigned WIDTH_P = 8,
    parameter int unsigned IMG_W_P = 16,
    localparam int unsigned COL_W  = $clog2(IMG_W_P)
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [COL_W-1:0]   col_i,
    input  logic [WIDTH_P-1:0] data_i,
    output logic [WIDTH_P-1:0] row1_o,
    output logic [WIDTH_P-1:0] row2_o
);

    logic [WIDTH_P-1:0] line1_q [IMG_W_P];
    logic [WIDTH_P-1:0] line2_q [IMG_W_P];

    // Contents are never cleared: they are only consumed once two full rows are written.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            line1_q[col_i] <= data_i;
            line2_q[col_i] <= line1_q[col_i];
        end
    end

    assign row1_o = line1_q[col_i];
    assign row2_o = line2_q[col_i];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 Sobel/Prewitt/Scharr gradient with valid/ready backpressure.
// Define CONV3X3_MAG_EN to add a saturated |gx|+|gy| stage (latency 3 instead of 2).
module conv3x3_stream
    import conv3x3_pkg::*;
#(
    parameter int unsigned WIDTH_P = 8,
    parameter int unsigned IMG_W_P = 16,
    parameter int unsigned IMG_H_P = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH_P-1:0]   data_i,
    input  logic [1:0]           mode_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [2*WIDTH_P-1:0] gx_o,
    output logic [2*WIDTH_P-1:0] gy_o,
    output logic [WIDTH_P-1:0]   mag_o,
    output logic                 eof_o
);

    localparam int unsigned DW    = WIDTH_P + 1;
    localparam int unsigned GW    = grad_width(WIDTH_P);
    localparam int unsigned OW    = 2 * WIDTH_P;
    localparam int unsigned COL_W = $clog2(IMG_W_P);
    localparam int unsigned ROW_W = $clog2(IMG_H_P);

    logic adv_c, accept_c;
    logic [WIDTH_P-1:0] row1_c, row2_c;

    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    kernel_mode_e       mode_q, mode_d;
    logic [WIDTH_P-1:0] win_q [3][3];
    logic [WIDTH_P-1:0] win_d [3][3];
    logic               win_vld_q, win_vld_d, win_eof_q, win_eof_d;

    logic signed [DW-1:0] s1_dx_q [3];
    logic signed [DW-1:0] s1_dx_d [3];
    logic signed [DW-1:0] s1_dy_q [3];
    logic signed [DW-1:0] s1_dy_d [3];
    logic                 s1_vld_q, s1_vld_d, s1_eof_q, s1_eof_d;
    kernel_mode_e         s1_mode_q, s1_mode_d;

    logic signed [GW-1:0] w_outer_c, w_inner_c, gx_sum_c, gy_sum_c;
    logic signed [GW-1:0] s2_gx_q, s2_gx_d, s2_gy_q, s2_gy_d;
    logic                 s2_vld_q, s2_vld_d, s2_eof_q, s2_eof_d;

    // Whole pipe advances together; it only freezes while a held output is refused.
    assign adv_c    = ~valid_o | ready_i;
    assign ready_o  = adv_c;
    assign accept_c = valid_i & adv_c;

    conv3x3_linebuf #(
        .WIDTH_P(WIDTH_P),
        .IMG_W_P(IMG_W_P)
    ) u_linebuf (
        .clk_i (clk_i),
        .we_i  (accept_c),
        .col_i (col_q),
        .data_i(data_i),
        .row1_o(row1_c),
        .row2_o(row2_c)
    );

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        mode_d    = mode_q;
        win_d     = win_q;
        win_vld_d = win_vld_q;
        win_eof_d = win_eof_q;
        s1_dx_d   = s1_dx_q;
        s1_dy_d   = s1_dy_q;
        s1_vld_d  = s1_vld_q;
        s1_eof_d  = s1_eof_q;
        s1_mode_d = s1_mode_q;
        s2_gx_d   = s2_gx_q;
        s2_gy_d   = s2_gy_q;
        s2_vld_d  = s2_vld_q;
        s2_eof_d  = s2_eof_q;

        if (accept_c) begin
            if (col_q == COL_W'(IMG_W_P - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_H_P - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (col_q == '0 && row_q == '0) begin
                mode_d = decode_mode(mode_i);
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = row2_c;
            win_d[1][2] = row1_c;
            win_d[2][2] = data_i;
        end

        if (adv_c) begin
            win_vld_d = accept_c && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
            win_eof_d = accept_c && (row_q == ROW_W'(IMG_H_P - 1)) && (col_q == COL_W'(IMG_W_P - 1));
            for (int i = 0; i < 3; i++) begin
                s1_dx_d[i] = DW'(win_q[i][2]) - DW'(win_q[i][0]);
                s1_dy_d[i] = DW'(win_q[2][i]) - DW'(win_q[0][i]);
            end
            s1_vld_d  = win_vld_q;
            s1_eof_d  = win_eof_q;
            s1_mode_d = mode_q;
            s2_gx_d   = gx_sum_c;
            s2_gy_d   = gy_sum_c;
            s2_vld_d  = s1_vld_q;
            s2_eof_d  = s1_eof_q;
        end
    end

    // Kernel is separable: outer*(d0+d2) + inner*d1 for each direction.
    always_comb begin
        w_outer_c = GW'(outer_weight(s1_mode_q));
        w_inner_c = GW'(inner_weight(s1_mode_q));
        gx_sum_c  = w_outer_c * (GW'(s1_dx_q[0]) + GW'(s1_dx_q[2])) + w_inner_c * GW'(s1_dx_q[1]);
        gy_sum_c  = w_outer_c * (GW'(s1_dy_q[0]) + GW'(s1_dy_q[2])) + w_inner_c * GW'(s1_dy_q[1]);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            col_q     <= '0;
            row_q     <= '0;
            mode_q    <= KM_SOBEL;
            win_q     <= '{default: '0};
            win_vld_q <= 1'b0;
            win_eof_q <= 1'b0;
            s1_dx_q   <= '{default: '0};
            s1_dy_q   <= '{default: '0};
            s1_vld_q  <= 1'b0;
            s1_eof_q  <= 1'b0;
            s1_mode_q <= KM_SOBEL;
            s2_gx_q   <= '0;
            s2_gy_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_eof_q  <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            mode_q    <= mode_d;
            win_q     <= win_d;
            win_vld_q <= win_vld_d;
            win_eof_q <= win_eof_d;
            s1_dx_q   <= s1_dx_d;
            s1_dy_q   <= s1_dy_d;
            s1_vld_q  <= s1_vld_d;
            s1_eof_q  <= s1_eof_d;
            s1_mode_q <= s1_mode_d;
            s2_gx_q   <= s2_gx_d;
            s2_gy_q   <= s2_gy_d;
            s2_vld_q  <= s2_vld_d;
            s2_eof_q  <= s2_eof_d;
        end
    end

`ifdef CONV3X3_MAG_EN
    localparam int unsigned MAG_MAX = (2 ** WIDTH_P) - 1;

    logic [GW-1:0]        abs_gx_c, abs_gy_c;
    logic [GW:0]          abs_sum_c;
    logic signed [GW-1:0] s3_gx_q, s3_gx_d, s3_gy_q, s3_gy_d;
    logic [WIDTH_P-1:0]   s3_mag_q, s3_mag_d;
    logic                 s3_vld_q, s3_vld_d, s3_eof_q, s3_eof_d;

    always_comb begin
        abs_gx_c  = s2_gx_q[GW-1] ? GW'(-s2_gx_q) : GW'(s2_gx_q);
        abs_gy_c  = s2_gy_q[GW-1] ? GW'(-s2_gy_q) : GW'(s2_gy_q);
        abs_sum_c = (GW+1)'(abs_gx_c) + (GW+1)'(abs_gy_c);
        s3_gx_d   = s3_gx_q;
        s3_gy_d   = s3_gy_q;
        s3_mag_d  = s3_mag_q;
        s3_vld_d  = s3_vld_q;
        s3_eof_d  = s3_eof_q;
        if (adv_c) begin
            s3_gx_d  = s2_gx_q;
            s3_gy_d  = s2_gy_q;
            s3_mag_d = (abs_sum_c > (GW+1)'(MAG_MAX)) ? '1 : WIDTH_P'(abs_sum_c);
            s3_vld_d = s2_vld_q;
            s3_eof_d = s2_eof_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            s3_gx_q  <= '0;
            s3_gy_q  <= '0;
            s3_mag_q <= '0;
            s3_vld_q <= 1'b0;
            s3_eof_q <= 1'b0;
        end else begin
            s3_gx_q  <= s3_gx_d;
            s3_gy_q  <= s3_gy_d;
            s3_mag_q <= s3_mag_d;
            s3_vld_q <= s3_vld_d;
            s3_eof_q <= s3_eof_d;
        end
    end

    assign valid_o = s3_vld_q;
    assign eof_o   = s3_vld_q & s3_eof_q;
    assign gx_o    = OW'(s3_gx_q);
    assign gy_o    = OW'(s3_gy_q);
    assign mag_o   = s3_mag_q;
`else
    assign valid_o = s2_vld_q;
    assign eof_o   = s2_vld_q & s2_eof_q;
    assign gx_o    = OW'(s2_gx_q);
    assign gy_o    = OW'(s2_gy_q);
    assign mag_o   = '0;
`endif

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream: random/directed frames against a kernel-matrix reference model.
module tb_conv3x3_stream;

    localparam int WIDTH = 8;
    localparam int W     = 8;
    localparam int H     = 6;
    localparam int NPIX  = W * H;
    localparam int NOUT  = (W - 2) * (H - 2);

    logic               clk;
    logic               rstn_i;
    logic               valid_i;
    logic               ready_o;
    logic [WIDTH-1:0]   data_i;
    logic [1:0]         mode_i;
    logic               valid_o;
    logic               ready_i;
    logic [2*WIDTH-1:0] gx_o;
    logic [2*WIDTH-1:0] gy_o;
    logic [WIDTH-1:0]   mag_o;
    logic               eof_o;

    conv3x3_stream #(
        .WIDTH_P(WIDTH),
        .IMG_W_P(W),
        .IMG_H_P(H)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .mode_i (mode_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .gx_o   (gx_o),
        .gy_o   (gy_o),
        .mag_o  (mag_o),
        .eof_o  (eof_o)
    );

    typedef struct {
        int gx;
        int gy;
        int mag;
        int eof;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   out_cnt = 0;
    int   img[H][W];
    int   frame_mode = 0;
    bit   rand_ready = 0;

    bit               held = 0;
    logic [2*WIDTH-1:0] h_gx, h_gy;
    logic [WIDTH-1:0] h_mag;
    logic             h_eof;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int weight(input int mode, input bit outer);
        if (mode == 1) return 1;
        if (mode == 2) return outer ? 3 : 10;
        return outer ? 1 : 2;
    endfunction

    function automatic int pix_val(input int kind, input int r, input int c);
        case (kind)
            0:       return c * 4;
            1:       return r * 4;
            2:       return (c < 4) ? 0 : 255;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // Reference: full 3x3 kernel built from the mode's edge/centre weights, centre (r-1,c-1).
    task automatic push_expected(input int r, input int c);
        exp_t e;
        int gx = 0;
        int gy = 0;
        int s;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int v = img[r-2+i][c-2+j];
                gx += (j - 1) * weight(frame_mode, i != 1) * v;
                gy += (i - 1) * weight(frame_mode, j != 1) * v;
            end
        end
        e.gx = gx;
        e.gy = gy;
`ifdef CONV3X3_MAG_EN
        s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        e.mag = (s > 255) ? 255 : s;
`else
        s = 0;
        e.mag = s;
`endif
        e.eof = (r == H - 1 && c == W - 1) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: outputs transfer on the next rising edge when valid_o & ready_i at the falling edge.
    always @(negedge clk) begin
        if (valid_o) begin
            if (held) begin
                check("hold_gx", int'(gx_o), int'(h_gx));
                check("hold_gy", int'(gy_o), int'(h_gy));
                check("hold_mag", int'(mag_o), int'(h_mag));
                check("hold_eof", int'(eof_o), int'(h_eof));
            end
            if (ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got gx=%0d gy=%0d with nothing expected",
                             $signed(gx_o), $signed(gy_o));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("gx", int'($signed(gx_o)), mon_e.gx);
                    check("gy", int'($signed(gy_o)), mon_e.gy);
                    check("mag", int'(mag_o), mon_e.mag);
                    check("eof", int'(eof_o), mon_e.eof);
                end
                out_cnt++;
                held = 0;
            end else begin
                held  = 1;
                h_gx  = gx_o;
                h_gy  = gy_o;
                h_mag = mag_o;
                h_eof = eof_o;
            end
        end else if (held) begin
            check("hold_valid", int'(valid_o), 1);
            held = 0;
        end
    end

    task automatic send_pixel(input int r, input int c, input int val, input int mode);
        int waitc = 0;
        valid_i = 1'b1;
        data_i  = WIDTH'(val);
        mode_i  = 2'(mode);
        @(negedge clk);
        while (!ready_o && waitc < 2000) begin
            @(negedge clk);
            waitc++;
        end
        if (!ready_o) begin
            check("accept_timeout", 0, 1);
            valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        img[r][c] = val;
        if (r == 0 && c == 0) frame_mode = mode;
        if (r >= 2 && c >= 2) push_expected(r, c);
    endtask

    task automatic send_frame(input int kind, input int mode_a, input int mode_b,
                              input int switch_at, input bit gaps, input int stop_at);
        for (int idx = 0; idx < NPIX; idx++) begin
            int r = idx / W;
            int c = idx % W;
            if (idx == stop_at) return;
            send_pixel(r, c, pix_val(kind, r, c), (idx < switch_at) ? mode_a : mode_b);
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic drain(input string name, input int expect_n);
        int waitc = 0;
        while (exp_q.size() != 0 && waitc < 2000) begin
            @(posedge clk);
            waitc++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
        check(name, out_cnt, expect_n);
        out_cnt = 0;
    endtask

    task automatic run_frame(input string name, input int kind, input int mode_a, input int mode_b,
                             input int switch_at, input bit gaps);
        out_cnt = 0;
        send_frame(kind, mode_a, mode_b, switch_at, gaps, -1);
        drain(name, NOUT);
    endtask

    initial begin
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        mode_i  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(valid_o), 0);
        check("rst_eof", int'(eof_o), 0);
        check("rst_gx", int'(gx_o), 0);
        check("rst_gy", int'(gy_o), 0);
        check("rst_mag", int'(mag_o), 0);
        check("rst_ready", int'(ready_o), 1);
        rstn_i = 1'b1;
        @(posedge clk);
        #1;

        run_frame("cnt_sobel_ramp", 0, 0, 0, NPIX, 0);
        run_frame("cnt_prewitt_ramp", 0, 1, 1, NPIX, 0);
        run_frame("cnt_scharr_ramp", 0, 2, 2, NPIX, 0);
        run_frame("cnt_sobel_vramp", 1, 0, 0, NPIX, 0);

        rand_ready = 1;
        run_frame("cnt_stall_ramp", 0, 0, 0, NPIX, 1);
        rand_ready = 0;

        run_frame("cnt_mode_midframe", 0, 0, 2, 3 * W + 2, 0);
        run_frame("cnt_mode_next", 0, 2, 2, NPIX, 0);

        // Reset while pixel (4,5) is next: in-flight results are discarded.
        send_frame(0, 0, 0, NPIX, 0, 4 * W + 5);
        rstn_i = 1'b0;
        @(posedge clk);
        #1;
        rstn_i = 1'b1;
        exp_q.delete();
        held = 0;
        check("midrst_valid", int'(valid_o), 0);
        check("midrst_eof", int'(eof_o), 0);
        run_frame("cnt_after_reset", 0, 0, 0, NPIX, 0);

        run_frame("cnt_step", 2, 0, 0, NPIX, 0);
        run_frame("cnt_step_scharr", 2, 2, 2, NPIX, 0);

        rand_ready = 1;
        for (int f = 0; f < 4; f++) begin
            int m = int'($urandom_range(0, 3));
            run_frame("cnt_random", 3, m, m, NPIX, 1);
        end
        rand_ready = 0;

        check("final_idle", int'(valid_o), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
